// File: rtl/cache_lv1_pkg.sv
// Shared LV1 cache types: snoop command encoding, address field bounds
// and the queued snoop entry layout.
package cache_lv1_pkg;

    localparam int ADDR_WID_LV1   = 32;
    localparam int TAG_MSB_LV1    = 31;
    localparam int TAG_LSB_LV1    = 14;
    localparam int INDEX_MSB_LV1  = 13;
    localparam int INDEX_LSB_LV1  = 2;
    localparam int OFFSET_MSB_LV1 = 1;
    localparam int OFFSET_LSB_LV1 = 0;

    localparam int TAG_WID_LV1    = TAG_MSB_LV1 - TAG_LSB_LV1 + 1;
    localparam int INDEX_WID_LV1  = INDEX_MSB_LV1 - INDEX_LSB_LV1 + 1;
    localparam int OFFSET_WID_LV1 = OFFSET_MSB_LV1 - OFFSET_LSB_LV1 + 1;

    typedef enum logic [1:0] {
        SNP_NONE = 2'd0,
        SNP_RD   = 2'd1,
        SNP_RDX  = 2'd2,
        SNP_INV  = 2'd3
    } snoop_cmd_t;

    typedef struct packed {
        snoop_cmd_t                cmd;
        logic [TAG_WID_LV1-1:0]    tag;
        logic [INDEX_WID_LV1-1:0]  index;
        logic [OFFSET_WID_LV1-1:0] offset;
    } snoop_entry_t;

    // RDX wins over RD, which wins over INV.
    function automatic snoop_cmd_t encode_cmd(
        input logic rd,
        input logic rdx,
        input logic inv
    );
        snoop_cmd_t c;
        c = SNP_NONE;
        if (rdx)      c = SNP_RDX;
        else if (rd)  c = SNP_RD;
        else if (inv) c = SNP_INV;
        return c;
    endfunction

endpackage

// File: rtl/snoop_fifo_lv1.sv
// Synchronous FIFO of snoop entries; a push into a full FIFO only
// lands when a pop frees a slot in the same cycle.
module snoop_fifo_lv1
    import cache_lv1_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  snoop_entry_t             din,
    output snoop_entry_t             dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    snoop_entry_t       mem_q [DEPTH];
    snoop_entry_t       mem_d [DEPTH];
    logic [PW-1:0]      wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]      rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]      count_q, count_d;
    logic               do_push;
    logic               do_pop;

    assign empty = (count_q == '0);
    assign full  = (count_q == CW'(DEPTH));
    assign count = count_q;
    assign dout  = mem_q[rd_ptr_q];

    // Next-state for storage, pointers and occupancy.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        do_pop   = pop && !empty;
        do_push  = push && (!full || do_pop);
        if (do_push) begin
            mem_d[wr_ptr_q] = din;
            wr_ptr_d        = wr_ptr_q + PW'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end
        if (do_push && !do_pop) begin
            count_d = count_q + CW'(1);
        end else if (!do_push && do_pop) begin
            count_d = count_q - CW'(1);
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/snoop_req_queue_lv1.sv
// Snoop request queue: encodes bus snoop commands, filters own-core and
// repeated level requests, and buffers split addresses for the snoop FSM.
module snoop_req_queue_lv1
    import cache_lv1_pkg::*;
#(
    parameter int                     ADDR_WID    = ADDR_WID_LV1,
    parameter int                     DEPTH       = 4,
    parameter int                     CORE_ID_WID = 2,
    parameter logic [CORE_ID_WID-1:0] CORE_ID     = '0
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      bus_rd,
    input  logic                      bus_rdx,
    input  logic                      invalidate,
    input  logic [ADDR_WID-1:0]       address,
    input  logic [CORE_ID_WID-1:0]    req_core_id,
    output logic                      snoop_valid,
    input  logic                      snoop_ready,
    output logic [1:0]                snoop_cmd,
    output logic [TAG_WID_LV1-1:0]    tag_snoop,
    output logic [INDEX_WID_LV1-1:0]  index_snoop,
    output logic [OFFSET_WID_LV1-1:0] blk_offset_snoop,
    output logic                      q_full,
    output logic [$clog2(DEPTH):0]    q_count,
    output logic                      overflow_err,
    output logic                      cmd_err
);

    snoop_cmd_t          prev_cmd_q, prev_cmd_d;
    logic [ADDR_WID-1:0] prev_addr_q, prev_addr_d;
    logic                ovf_q, ovf_d;
    logic                cerr_q, cerr_d;

    snoop_cmd_t          cmd;
    logic                multi;
    logic                new_req;
    logic                push;
    logic                pop;
    snoop_entry_t        entry;
    snoop_entry_t        head;
    logic                full;
    logic                empty;

    // Encode, filter and build the entry; update sample and sticky errors.
    always_comb begin
        cmd   = encode_cmd(bus_rd, bus_rdx, invalidate);
        multi = (bus_rd & bus_rdx) | (bus_rd & invalidate)
              | (bus_rdx & invalidate);
        new_req = (cmd != SNP_NONE)
               && (req_core_id != CORE_ID)
               && ((cmd != prev_cmd_q) || (address != prev_addr_q));
        pop  = !empty && snoop_ready;
        push = new_req && (!full || pop);

        entry        = '0;
        entry.cmd    = cmd;
        entry.tag    = address[TAG_MSB_LV1:TAG_LSB_LV1];
        entry.index  = address[INDEX_MSB_LV1:INDEX_LSB_LV1];
        entry.offset = address[OFFSET_MSB_LV1:OFFSET_LSB_LV1];

        prev_cmd_d  = cmd;
        prev_addr_d = address;
        ovf_d       = ovf_q | (new_req && full && !pop);
        cerr_d      = cerr_q | multi;
    end

    // Previous-cycle sample and sticky error registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            prev_cmd_q  <= SNP_NONE;
            prev_addr_q <= '0;
            ovf_q       <= 1'b0;
            cerr_q      <= 1'b0;
        end else begin
            prev_cmd_q  <= prev_cmd_d;
            prev_addr_q <= prev_addr_d;
            ovf_q       <= ovf_d;
            cerr_q      <= cerr_d;
        end
    end

    snoop_fifo_lv1 #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .din   (entry),
        .dout  (head),
        .full  (full),
        .empty (empty),
        .count (q_count)
    );

    assign snoop_valid      = !empty;
    assign snoop_cmd        = empty ? 2'd0 : head.cmd;
    assign tag_snoop        = empty ? '0 : head.tag;
    assign index_snoop      = empty ? '0 : head.index;
    assign blk_offset_snoop = empty ? '0 : head.offset;
    assign q_full           = full;
    assign overflow_err     = ovf_q;
    assign cmd_err          = cerr_q;

endmodule

// File: tb/tb_snoop_req_queue_lv1.sv
// Bench for snoop_req_queue_lv1: directed scenarios followed by random
// traffic, all checked against a queue-based reference model.
module tb_snoop_req_queue_lv1;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        bus_rd = 1'b0;
    logic        bus_rdx = 1'b0;
    logic        invalidate = 1'b0;
    logic [31:0] address = '0;
    logic [1:0]  req_core_id = '0;
    logic        snoop_ready = 1'b0;
    logic        snoop_valid;
    logic [1:0]  snoop_cmd;
    logic [17:0] tag_snoop;
    logic [11:0] index_snoop;
    logic [1:0]  blk_offset_snoop;
    logic        q_full;
    logic [2:0]  q_count;
    logic        overflow_err;
    logic        cmd_err;

    int passed = 0;
    int total  = 0;

    logic [1:0]  m_cmd  [$];
    logic [31:0] m_addr [$];
    logic [1:0]  m_prev_cmd = '0;
    logic [31:0] m_prev_addr = '0;
    logic        m_ovf = 1'b0;
    logic        m_cerr = 1'b0;

    always #5 clk = ~clk;

    snoop_req_queue_lv1 #(
        .ADDR_WID    (32),
        .DEPTH       (4),
        .CORE_ID_WID (2),
        .CORE_ID     (2'd0)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .bus_rd           (bus_rd),
        .bus_rdx          (bus_rdx),
        .invalidate       (invalidate),
        .address          (address),
        .req_core_id      (req_core_id),
        .snoop_valid      (snoop_valid),
        .snoop_ready      (snoop_ready),
        .snoop_cmd        (snoop_cmd),
        .tag_snoop        (tag_snoop),
        .index_snoop      (index_snoop),
        .blk_offset_snoop (blk_offset_snoop),
        .q_full           (q_full),
        .q_count          (q_count),
        .overflow_err     (overflow_err),
        .cmd_err          (cmd_err)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    // Compare every output against the model's view of the queue.
    task automatic check_all();
        logic [1:0]  ec;
        logic [31:0] ea;
        ec = 2'd0;
        ea = 32'd0;
        if (m_cmd.size() > 0) begin
            ec = m_cmd[0];
            ea = m_addr[0];
        end
        chk("valid",  32'(snoop_valid), 32'(m_cmd.size() > 0));
        chk("cmd",    32'(snoop_cmd), 32'(ec));
        chk("tag",    32'(tag_snoop), ea >> 14);
        chk("index",  32'(index_snoop), (ea >> 2) & 32'hFFF);
        chk("offset", 32'(blk_offset_snoop), ea & 32'h3);
        chk("full",   32'(q_full), 32'(m_cmd.size() == 4));
        chk("count",  32'(q_count), 32'(m_cmd.size()));
        chk("ovf",    32'(overflow_err), 32'(m_ovf));
        chk("cmderr", 32'(cmd_err), 32'(m_cerr));
    endtask

    // Apply one cycle of inputs, advance the model across the edge, check.
    task automatic step(input bit r, input bit rd, input bit rdx,
                        input bit inv, input logic [31:0] a,
                        input logic [1:0] id, input bit rdy);
        logic [1:0] c;
        bit         nreq;
        bit         pop;
        int         ncmds;
        rst         = r;
        bus_rd      = rd;
        bus_rdx     = rdx;
        invalidate  = inv;
        address     = a;
        req_core_id = id;
        snoop_ready = rdy;
        c     = rdx ? 2'd2 : rd ? 2'd1 : inv ? 2'd3 : 2'd0;
        ncmds = int'(rd) + int'(rdx) + int'(inv);
        nreq  = (c != 0) && (id != 2'd0)
             && !(c == m_prev_cmd && a == m_prev_addr);
        pop   = (m_cmd.size() > 0) && rdy;
        @(posedge clk);
        if (r) begin
            m_cmd.delete();
            m_addr.delete();
            m_prev_cmd  = '0;
            m_prev_addr = '0;
            m_ovf       = 1'b0;
            m_cerr      = 1'b0;
        end else begin
            if (nreq && m_cmd.size() == 4 && !pop) m_ovf = 1'b1;
            if (ncmds > 1) m_cerr = 1'b1;
            if (pop) begin
                void'(m_cmd.pop_front());
                void'(m_addr.pop_front());
            end
            if (nreq && (m_cmd.size() < 4)) begin
                m_cmd.push_back(c);
                m_addr.push_back(a);
            end
            m_prev_cmd  = c;
            m_prev_addr = a;
        end
        #1;
        check_all();
    endtask

    task automatic idle(input bit rdy);
        step(0, 0, 0, 0, 32'h0, 2'd1, rdy);
    endtask

    initial begin
        // Reset state
        step(1, 0, 0, 0, 32'h0, 2'd0, 0);
        step(1, 0, 0, 0, 32'h0, 2'd0, 0);

        // Level-held RD from core 1 yields one entry
        step(0, 1, 0, 0, 32'hABCD1234, 2'd1, 0);
        chk("rd_cmd_const", 32'(snoop_cmd), 32'd1);
        chk("rd_tag_const", 32'(tag_snoop), 32'h2AF34);
        chk("rd_idx_const", 32'(index_snoop), 32'h48D);
        chk("rd_off_const", 32'(blk_offset_snoop), 32'd0);
        step(0, 1, 0, 0, 32'hABCD1234, 2'd1, 0);
        step(0, 1, 0, 0, 32'hABCD1234, 2'd1, 0);
        chk("rd_held_count", 32'(q_count), 32'd1);
        idle(1);
        // Deassert/reassert gives a second entry
        step(0, 1, 0, 0, 32'hABCD1234, 2'd1, 0);
        idle(1);

        // Own-core RDX is filtered
        step(0, 0, 1, 0, 32'h11112222, 2'd0, 0);
        step(0, 0, 1, 0, 32'h11112222, 2'd0, 0);
        chk("self_valid", 32'(snoop_valid), 32'd0);
        chk("self_count", 32'(q_count), 32'd0);

        // Five distinct RDs overflow a 4-deep FIFO; drain in order
        for (int i = 0; i < 5; i++)
            step(0, 1, 0, 0, 32'h1000_0000 + 32'(i) * 32'h44, 2'd2, 0);
        idle(0);
        chk("ovf_full",  32'(q_full), 32'd1);
        chk("ovf_count", 32'(q_count), 32'd4);
        chk("ovf_flag",  32'(overflow_err), 32'd1);
        for (int i = 0; i < 5; i++) idle(1);

        // Full with simultaneous push and pop
        step(1, 0, 0, 0, 32'h0, 2'd0, 0);
        for (int i = 0; i < 4; i++)
            step(0, 0, 0, 1, 32'h2000_0000 + 32'(i) * 32'h104, 2'd3, 0);
        step(0, 1, 0, 0, 32'h3000_0008, 2'd3, 1);
        chk("pp_count", 32'(q_count), 32'd4);
        chk("pp_ovf",   32'(overflow_err), 32'd0);
        for (int i = 0; i < 4; i++) idle(1);

        // Empty with push and ready: push lands
        step(0, 1, 0, 0, 32'h4000_0010, 2'd1, 1);

        // RD and RDX together encode RDX and flag cmd_err
        idle(1);
        step(0, 1, 1, 0, 32'h5000_0004, 2'd1, 0);
        idle(0);
        chk("multi_cmd", 32'(snoop_cmd), 32'd2);
        chk("multi_err", 32'(cmd_err), 32'd1);

        // Reset mid-queue
        step(0, 0, 0, 1, 32'h6000_0000, 2'd2, 0);
        step(1, 0, 0, 0, 32'h0, 2'd0, 0);
        chk("rst_valid", 32'(snoop_valid), 32'd0);
        chk("rst_count", 32'(q_count), 32'd0);
        chk("rst_err",   32'(cmd_err), 32'd0);

        // Random traffic against the model
        for (int i = 0; i < 400; i++) begin
            bit rr, rd, rdx, inv, rdy;
            logic [31:0] a;
            rr  = ($urandom_range(0, 99) == 0);
            rd  = ($urandom_range(0, 2) == 0);
            rdx = ($urandom_range(0, 3) == 0);
            inv = ($urandom_range(0, 3) == 0);
            rdy = ($urandom_range(0, 2) != 0);
            a   = ($urandom_range(0, 3) == 0) ? address
                : {$urandom_range(0, 3), 30'h0} | 32'($urandom_range(0, 7));
            step(rr, rd, rdx, inv, a, 2'($urandom_range(0, 3)), rdy);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
